girl10_lock_gen: RTL and testbench
==================================

Name: girl10_lock_gen

Overview:
- Parametrised successor to the single-key, single-duplicate girl10 locked controller.
- 6-state Mealy controller with the same functional outputs y1..y10 (no y5).
- The S5->S1 return is gated by a KEY_W-bit key. A wrong key diverts to one of NUM_DUP shadow copies of S1, selected by the key mismatch pattern.
- Sits in the locked-benchmark set as the generic template for key-width and duplicate-count sweeps.

Parameters:
- KEY_W, 4, key width in bits (1..16).
- NUM_DUP, 2, number of shadow copies of S1 (1..8).
- CORRECT_KEY, 4'b1011, KEY_W-bit unlocking value.
- ST_W, derived = clog2(7+NUM_DUP), state register width; not user-set.

Ports:
- clk  in  1  single clock; state updates on the falling edge, as in the girl family.
- rst  in  1  synchronous, active-low reset, sampled on the same clk edge.
- x1..x7  in  1 each  controller condition inputs.
- keyinput  in  KEY_W  lock key.
- y1,y2,y3,y4,y6,y7,y8,y9,y10  out  1 each  controller outputs.

Behaviour:
- Encoding and reset:
  - States: S1=1, S2..S6=2..6, D0..D(NUM_DUP-1)=7..6+NUM_DUP. Encoding 0 and codes above 6+NUM_DUP are illegal.
  - rst==0 at a clk falling edge: state<=S1.
  - Outputs are combinational from state and inputs (Mealy); all outputs default 0 each evaluation.
- S1: x6 -> y8,y9=1, next S2; ~x6&x7 -> y6, next S3; ~x6&~x7 -> y3,y6,y10, next S3.
- Dj (each j): identical outputs and transitions to S1. No exit back to S1 except via the normal S2..S5 loop.
- S2: x4&x1 -> y1,y2, stay S2; x4&~x1 -> y3,y4, next S4; ~x4 -> y4, next S5.
- S3:
  - x1&x2&x3 -> y1,y3, next S2.
  - x1&x2&~x3 -> y6,y7, next S6.
  - x1&~x2 -> y1,y3, next S2.
  - ~x1 -> y4, next S5.
- S4: x6 -> y6,y7, next S3; ~x6 -> y3,y4, stay S4.
- S5:
  - x5, keyinput==CORRECT_KEY -> next S1, no outputs.
  - x5, key wrong -> next D(m mod NUM_DUP), where m = popcount(keyinput ^ CORRECT_KEY) - 1. The result is always in range.
  - ~x5&x1 -> y8,y9, next S2.
  - ~x5&~x1 -> y3,y4, next S4.
- S6: unconditionally y3,y4, next S4.
- Illegal encoding: all outputs 0, next S1 (recovers in one edge; the predecessor's transition to 0 is not reproduced).
- Key is sampled only when the next-state decision is taken in S5. Key changes in any other state have no effect.
- Reset mid-operation (any state, including Dj): S1 on that edge; rst takes priority over all inputs.
- Equivalence: for any key, the output sequence is identical to a correct-key run. Only the internal state encoding differs; the lock is structural.

Optional Feature:
- Macro: GIRL10_LOCK_REG_OUT_EN.
- Defined:
  - The 9 outputs are registered on the clk falling edge, giving one edge of latency versus the combinational value.
  - Output registers are cleared to 0 synchronously when rst==0.
  - Illegal state registers zeros.
- Undefined: outputs purely combinational as above.

Decomposition:
- Package girl10_lock_pkg holds:
  - state localparams S1..S6, D_BASE=7;
  - function clog2;
  - function dup_sel(key, correct, num_dup) returning the shadow index.
- One sub-module, girl10_lock_keycmp: combinational compare producing key_ok and dup_idx. It is reused by later multi-site variants.
- The FSM stays in a single module.

Test Plan:
- rst=0 for 2 edges, then rst=1, x6=1 -> state S1, y8=y9=1, all others 0; next edge state S2.
- Path S1->S3 (x6=0,x7=0: y3,y6,y10=1) -> S3 with x1=0 (y4=1) -> S5 with x5=1, keyinput=4'b1011 -> state S1.
- Same path with keyinput=4'b1010 (m=0) -> D0; keyinput=4'b0100 (m=3) -> D1. In each Dj, x6=1 gives y8=y9=1, next S2.
- Random 2000-cycle x stimulus, correct vs wrong key in two instances -> y outputs bit-identical every cycle.
- Force illegal state 0 / 15 (NUM_DUP=2) -> all outputs 0, state S1 after one edge. Assert rst=0 while in S4 -> S1 on that edge.
- With GIRL10_LOCK_REG_OUT_EN: the S6 entry edge is followed one edge later by y3=y4=1. rst=0 clears all outputs to 0 at the next edge.

Source files
------------

// File: rtl/girl10_lock_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | girl10_lock_pkg                                                   |
// | Shared state codes, output bundle type and helper functions for   |
// | the key-locked girl10 controller family.                          |
// | Contents: S1..S6 / D_BASE codes, y_t output bundle, clog2,        |
// |           dup_sel (shadow-copy index from a key mismatch).        |
// | Revision: 1.0 - initial parametrised release                      |
// +------------------------------------------------------------------+
package girl10_lock_pkg;

  localparam int S1     = 1;
  localparam int S2     = 2;
  localparam int S3     = 3;
  localparam int S4     = 4;
  localparam int S5     = 5;
  localparam int S6     = 6;
  localparam int D_BASE = 7;

  // The nine functional outputs; there is no y5 in this controller.
  typedef struct packed {
    logic y1;
    logic y2;
    logic y3;
    logic y4;
    logic y6;
    logic y7;
    logic y8;
    logic y9;
    logic y10;
  } y_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Shadow index = (popcount(key ^ correct) - 1) mod num_dup.
  // A matching key has no shadow; 0 is returned and ignored by callers.
  function automatic int dup_sel(input logic [15:0] key,
                                 input logic [15:0] correct,
                                 input int          num_dup);
    logic [15:0] diff;
    int          pc;
    diff = key ^ correct;
    pc   = 0;
    for (int i = 0; i < 16; i++) begin
      pc = pc + int'(diff[i]);
    end
    if (pc == 0) return 0;
    return (pc - 1) % num_dup;
  endfunction

endpackage
`default_nettype wire

// File: rtl/girl10_lock_keycmp.sv
`default_nettype none
// +------------------------------------------------------------------+
// | girl10_lock_keycmp                                                |
// | Combinational key compare: flags a correct key and, for a wrong   |
// | key, picks which shadow copy of S1 the controller diverts to.     |
// | Ports: key     in  KEY_W  lock key under test                     |
// |        key_ok  out 1      key equals CORRECT_KEY                  |
// |        dup_idx out IDX_W  shadow index (valid when key_ok==0)     |
// | Revision: 1.0 - initial parametrised release                      |
// +------------------------------------------------------------------+
module girl10_lock_keycmp
  import girl10_lock_pkg::*;
#(
  parameter int               KEY_W       = 4,
  parameter int               NUM_DUP     = 2,
  parameter logic [KEY_W-1:0] CORRECT_KEY = 4'b1011,
  parameter int               IDX_W       = (NUM_DUP > 1) ? clog2(NUM_DUP) : 1
) (
  input  logic [KEY_W-1:0] key,
  output logic             key_ok,
  output logic [IDX_W-1:0] dup_idx
);

  assign key_ok  = (key == CORRECT_KEY);
  assign dup_idx = IDX_W'(dup_sel(16'(key), 16'(CORRECT_KEY), NUM_DUP));

endmodule
`default_nettype wire

// File: rtl/girl10_lock_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | girl10_lock_gen                                                   |
// | Key-locked girl10 Mealy controller, generic in key width and in   |
// | the number of shadow copies of S1. A wrong key at the S5->S1      |
// | return lands in a shadow state that behaves exactly like S1, so   |
// | the output sequence never depends on the key.                     |
// | Ports: clk (state updates on the falling edge), rst (sync,        |
// |        active-low), x1..x7 condition inputs, keyinput[KEY_W],     |
// |        y1,y2,y3,y4,y6,y7,y8,y9,y10 outputs.                       |
// | Option: GIRL10_LOCK_REG_OUT_EN registers the outputs on the       |
// |         falling edge (one edge of latency, cleared by rst).       |
// | Revision: 1.0 - initial parametrised release                      |
// +------------------------------------------------------------------+
module girl10_lock_gen
  import girl10_lock_pkg::*;
#(
  parameter int               KEY_W       = 4,
  parameter int               NUM_DUP     = 2,
  parameter logic [KEY_W-1:0] CORRECT_KEY = 4'b1011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x1,
  input  logic             x2,
  input  logic             x3,
  input  logic             x4,
  input  logic             x5,
  input  logic             x6,
  input  logic             x7,
  input  logic [KEY_W-1:0] keyinput,
  output logic             y1,
  output logic             y2,
  output logic             y3,
  output logic             y4,
  output logic             y6,
  output logic             y7,
  output logic             y8,
  output logic             y9,
  output logic             y10
);

  localparam int ST_W  = clog2(7 + NUM_DUP);
  localparam int IDX_W = (NUM_DUP > 1) ? clog2(NUM_DUP) : 1;

  localparam logic [ST_W-1:0] ST_S1    = ST_W'(S1);
  localparam logic [ST_W-1:0] ST_S2    = ST_W'(S2);
  localparam logic [ST_W-1:0] ST_S3    = ST_W'(S3);
  localparam logic [ST_W-1:0] ST_S4    = ST_W'(S4);
  localparam logic [ST_W-1:0] ST_S5    = ST_W'(S5);
  localparam logic [ST_W-1:0] ST_S6    = ST_W'(S6);
  localparam logic [ST_W-1:0] ST_DBASE = ST_W'(D_BASE);
  localparam logic [ST_W-1:0] ST_DLAST = ST_W'(D_BASE + NUM_DUP - 1);

  logic [ST_W-1:0]  state;
  logic [ST_W-1:0]  state_nxt;
  logic             is_dup;
  logic             key_ok;
  logic [IDX_W-1:0] dup_idx;
  y_t               y_c;
  y_t               y_o;

  girl10_lock_keycmp #(
    .KEY_W       (KEY_W),
    .NUM_DUP     (NUM_DUP),
    .CORRECT_KEY (CORRECT_KEY),
    .IDX_W       (IDX_W)
  ) u_keycmp (
    .key     (keyinput),
    .key_ok  (key_ok),
    .dup_idx (dup_idx)
  );

  assign is_dup = (state >= ST_DBASE) && (state <= ST_DLAST);

  // Next state and Mealy outputs. Anything unrecognised (code 0 or above
  // the last shadow) falls through to the defaults: outputs 0, next S1.
  always_comb begin
    state_nxt = ST_S1;
    y_c       = '0;
    if ((state == ST_S1) || is_dup) begin
      if (x6) begin
        y_c.y8 = 1'b1; y_c.y9 = 1'b1;
        state_nxt = ST_S2;
      end else if (x7) begin
        y_c.y6 = 1'b1;
        state_nxt = ST_S3;
      end else begin
        y_c.y3 = 1'b1; y_c.y6 = 1'b1; y_c.y10 = 1'b1;
        state_nxt = ST_S3;
      end
    end else begin
      case (state)
        ST_S2: begin
          if (x4 && x1) begin
            y_c.y1 = 1'b1; y_c.y2 = 1'b1;
            state_nxt = ST_S2;
          end else if (x4) begin
            y_c.y3 = 1'b1; y_c.y4 = 1'b1;
            state_nxt = ST_S4;
          end else begin
            y_c.y4 = 1'b1;
            state_nxt = ST_S5;
          end
        end
        ST_S3: begin
          if (x1 && x2 && !x3) begin
            y_c.y6 = 1'b1; y_c.y7 = 1'b1;
            state_nxt = ST_S6;
          end else if (x1) begin
            // x2&x3 and ~x2 share the same response
            y_c.y1 = 1'b1; y_c.y3 = 1'b1;
            state_nxt = ST_S2;
          end else begin
            y_c.y4 = 1'b1;
            state_nxt = ST_S5;
          end
        end
        ST_S4: begin
          if (x6) begin
            y_c.y6 = 1'b1; y_c.y7 = 1'b1;
            state_nxt = ST_S3;
          end else begin
            y_c.y3 = 1'b1; y_c.y4 = 1'b1;
            state_nxt = ST_S4;
          end
        end
        ST_S5: begin
          if (x5) begin
            // The key is only looked at here; no outputs on this return.
            state_nxt = key_ok ? ST_S1 : (ST_DBASE + ST_W'(dup_idx));
          end else if (x1) begin
            y_c.y8 = 1'b1; y_c.y9 = 1'b1;
            state_nxt = ST_S2;
          end else begin
            y_c.y3 = 1'b1; y_c.y4 = 1'b1;
            state_nxt = ST_S4;
          end
        end
        ST_S6: begin
          y_c.y3 = 1'b1; y_c.y4 = 1'b1;
          state_nxt = ST_S4;
        end
        default: begin
          state_nxt = ST_S1;
        end
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (!rst) state <= ST_S1;
    else      state <= state_nxt;
  end

`ifdef GIRL10_LOCK_REG_OUT_EN
  y_t y_r;
  always_ff @(negedge clk) begin
    if (!rst) y_r <= '0;
    else      y_r <= y_c;
  end
  assign y_o = y_r;
`else
  assign y_o = y_c;
`endif

  assign y1  = y_o.y1;
  assign y2  = y_o.y2;
  assign y3  = y_o.y3;
  assign y4  = y_o.y4;
  assign y6  = y_o.y6;
  assign y7  = y_o.y7;
  assign y8  = y_o.y8;
  assign y9  = y_o.y9;
  assign y10 = y_o.y10;

endmodule
`default_nettype wire

// File: tb/tb_girl10_lock_gen.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | tb_girl10_lock_gen                                                |
// | Two controller instances share x/rst but take separate keys.      |
// | A behavioural model predicts outputs and state per instance; a    |
// | monitor pops the predictions and compares them to the DUTs.       |
// | Revision: 1.0 - initial release                                   |
// +------------------------------------------------------------------+
module tb_girl10_lock_gen;

  localparam int         KEY_W   = 4;
  localparam int         NUM_DUP = 2;
  localparam logic [3:0] CK      = 4'b1011;

  // Bit positions in the 9-bit output vector {y1,y2,y3,y4,y6,y7,y8,y9,y10}
  localparam int B1 = 8, B2 = 7, B3 = 6, B4 = 5, B6 = 4, B7 = 3, B8 = 2, B9 = 1, B10 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic [7:1] x   = '0;
  logic [3:0] key_a = CK, key_b = CK;
  logic a1, a2, a3, a4, a6, a7, a8, a9, a10;
  logic b1, b2, b3, b4, b6, b7, b8, b9, b10;
  logic [8:0] ya, yb;
  assign ya = {a1, a2, a3, a4, a6, a7, a8, a9, a10};
  assign yb = {b1, b2, b3, b4, b6, b7, b8, b9, b10};

  girl10_lock_gen #(.KEY_W(KEY_W), .NUM_DUP(NUM_DUP), .CORRECT_KEY(CK)) dut_a (
    .clk(clk), .rst(rst), .x1(x[1]), .x2(x[2]), .x3(x[3]), .x4(x[4]), .x5(x[5]),
    .x6(x[6]), .x7(x[7]), .keyinput(key_a),
    .y1(a1), .y2(a2), .y3(a3), .y4(a4), .y6(a6), .y7(a7), .y8(a8), .y9(a9), .y10(a10));

  girl10_lock_gen #(.KEY_W(KEY_W), .NUM_DUP(NUM_DUP), .CORRECT_KEY(CK)) dut_b (
    .clk(clk), .rst(rst), .x1(x[1]), .x2(x[2]), .x3(x[3]), .x4(x[4]), .x5(x[5]),
    .x6(x[6]), .x7(x[7]), .keyinput(key_b),
    .y1(b1), .y2(b2), .y3(b3), .y4(b4), .y6(b6), .y7(b7), .y8(b8), .y9(b9), .y10(b10));

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model states: 1..6 are S1..S6, 10+j is shadow copy Dj.
  function automatic void model(input int st, input logic [7:1] xi, input logic [3:0] key,
                                output int nst, output logic [8:0] y);
    int m;
    y = '0;
    nst = 1;
    if (st == 1 || st >= 10) begin
      if (xi[6])      begin y[B8] = 1; y[B9] = 1; nst = 2; end
      else if (xi[7]) begin y[B6] = 1; nst = 3; end
      else            begin y[B3] = 1; y[B6] = 1; y[B10] = 1; nst = 3; end
    end else if (st == 2) begin
      if (xi[4] && xi[1]) begin y[B1] = 1; y[B2] = 1; nst = 2; end
      else if (xi[4])     begin y[B3] = 1; y[B4] = 1; nst = 4; end
      else                begin y[B4] = 1; nst = 5; end
    end else if (st == 3) begin
      if (!xi[1])      begin y[B4] = 1; nst = 5; end
      else if (!xi[2]) begin y[B1] = 1; y[B3] = 1; nst = 2; end
      else if (xi[3])  begin y[B1] = 1; y[B3] = 1; nst = 2; end
      else             begin y[B6] = 1; y[B7] = 1; nst = 6; end
    end else if (st == 4) begin
      if (xi[6]) begin y[B6] = 1; y[B7] = 1; nst = 3; end
      else       begin y[B3] = 1; y[B4] = 1; nst = 4; end
    end else if (st == 5) begin
      if (xi[5]) begin
        if (key == CK) nst = 1;
        else begin
          m   = $countones(key ^ CK) - 1;
          nst = 10 + (m % NUM_DUP);
        end
      end else if (xi[1]) begin y[B8] = 1; y[B9] = 1; nst = 2; end
      else                begin y[B3] = 1; y[B4] = 1; nst = 4; end
    end else if (st == 6) begin
      y[B3] = 1; y[B4] = 1; nst = 4;
    end
  endfunction

  function automatic int code(input int st);
    return (st >= 10) ? (7 + st - 10) : st;
  endfunction

  typedef struct {
    bit         chk;
    logic [8:0] ya;
    logic [8:0] yb;
    int         sa;
    int         sb;
  } exp_t;

  exp_t q[$];

  int         ma = 0, mb = 0;          // 0 = unknown before first reset
  logic [8:0] yreg_a = '0, yreg_b = '0;

  // One falling-edge step: drive, predict, push, advance the model.
  task automatic cycle(input logic r, input logic [7:1] xv,
                       input logic [3:0] ka, input logic [3:0] kb);
    exp_t       e;
    int         na, nb;
    logic [8:0] ca, cb;
    @(posedge clk); #1;
    rst = r; x = xv; key_a = ka; key_b = kb;
    model(ma, xv, ka, na, ca);
    model(mb, xv, kb, nb, cb);
    e.chk = (ma != 0);
`ifdef GIRL10_LOCK_REG_OUT_EN
    e.ya = yreg_a; e.yb = yreg_b;
    yreg_a = r ? ca : '0;
    yreg_b = r ? cb : '0;
`else
    e.ya = ca; e.yb = cb;
`endif
    e.sa = code(ma); e.sb = code(mb);
    q.push_back(e);
    if (!r) begin na = 1; nb = 1; end
    ma = na; mb = nb;
  endtask

  // Monitor: the outputs are live every cycle, sampled just before the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #4;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) begin
          check("y_a",     int'(ya), int'(e.ya));
          check("y_b",     int'(yb), int'(e.yb));
          check("state_a", int'(dut_a.state), e.sa);
          check("state_b", int'(dut_b.state), e.sb);
        end
      end
    end
  end

  localparam logic [7:1] X_NONE = 7'b0000000;
  localparam logic [7:1] X_6    = 7'b0100000;
  localparam logic [7:1] X_5    = 7'b0010000;
  localparam logic [7:1] X_4    = 7'b0001000;

  initial begin
    // reset for two edges, then S1 with x6
    cycle(1'b0, X_6, CK, CK);
    cycle(1'b0, X_6, CK, CK);
    cycle(1'b1, X_6, CK, CK);            // S1 -> S2, y8 y9
    cycle(1'b1, X_NONE, CK, CK);         // S2 -> S5, y4
    cycle(1'b1, X_5, CK, CK);            // S5 -> S1 (correct key)
    // S1 -> S3 -> S5, then wrong key 1010 on A (m=0 -> D0)
    cycle(1'b1, X_NONE, CK, CK);
    cycle(1'b1, X_NONE, CK, CK);
    cycle(1'b1, X_5, 4'b1010, CK);
    cycle(1'b1, X_6, 4'b0000, CK);       // D0 behaves as S1; later key ignored
    cycle(1'b1, X_NONE, CK, CK);         // S2 -> S5
    cycle(1'b1, X_5, 4'b0100, 4'b0100);  // m=3 -> D1 on both
    cycle(1'b1, X_6, CK, CK);            // D1 -> S2
    cycle(1'b1, X_4, CK, CK);            // S2 -> S4
    cycle(1'b1, X_NONE, CK, CK);         // S4 hold
    cycle(1'b0, X_NONE, CK, CK);         // reset from S4
    cycle(1'b1, X_6, CK, CK);            // back in S1

    // randomized run: A always correct key, B random key
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 63) != 0), 7'($urandom), CK, 4'($urandom));
    end

    // bounded drain of the scoreboard
    repeat (3) @(posedge clk);
    #5;
    check("queue_drained", q.size(), 0);

    // illegal encodings give all-zero outputs
    @(posedge clk); #1;
    x = X_6;
    force dut_a.state = 4'd0;
`ifdef GIRL10_LOCK_REG_OUT_EN
    @(negedge clk); #1;
`else
    #1;
`endif
    check("illegal0_y", int'(ya), 0);
    force dut_a.state = 4'd15;
`ifdef GIRL10_LOCK_REG_OUT_EN
    @(negedge clk); #1;
`else
    #1;
`endif
    check("illegal15_y", int'(ya), 0);
    release dut_a.state;

    // resynchronise both instances with the model
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    ma = 1; mb = 1; yreg_a = '0; yreg_b = '0;
    cycle(1'b1, X_6, CK, CK);
    cycle(1'b1, X_NONE, CK, 4'b1111);
    cycle(1'b1, X_NONE, CK, CK);
    repeat (3) @(posedge clk);
    #5;
    check("queue_drained_end", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
